dm_access_unit: RTL and testbench

Multicycle data-memory access sequencer. It sits directly upstream of the writeback select mux and produces the memory-data value (mdr) routed to the WDSEL_DM input. It takes a load/store request from the controller, runs a req/ack handshake with data memory, and handles byte lanes. It also aligns and sign- or zero-extends load data, and flags misaligned or illegal accesses and memory timeouts.

---
 rtl/dm_access_unit.sv | 162 ++++++++++++++++
 tb/tb_dm_access_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Data-memory access sequencer: issues one req/ack memory transaction per load/store,
// places store bytes on their lanes, and aligns and extends load data into mdr.
module dm_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mdr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        bad_q;
  logic [CNT_W-1:0] cnt_q;
  logic        mem_req_q, mem_we_q, busy_q, done_q, err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, mdr_q;
  logic [3:0]  mem_be_q;

  logic        access_ok_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted_d;
  logic [31:0] load_d;
  logic        timeout_hit;

  // Request decode from the controller inputs; only consumed when a start is accepted.
  always_comb begin
    access_ok_d = 1'b0;
    be_d        = 4'b1111;
    wdata_d     = wdata;
    case (funct3)
      3'b000: begin
        access_ok_d = 1'b1;
        if (is_store) be_d = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      3'b001: begin
        access_ok_d = ~addr[0];
        if (is_store) be_d = 4'b0011 << {addr[1], 1'b0};
        wdata_d = {2{wdata[15:0]}};
      end
      3'b010:  access_ok_d = (addr[1:0] == 2'b00);
      3'b100:  access_ok_d = ~is_store;
      3'b101:  access_ok_d = ~is_store & ~addr[0];
      default: access_ok_d = 1'b0;
    endcase
  end

  // Halfword lanes are always even, so one shift serves both byte and halfword loads.
  always_comb begin
    shifted_d = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b001:  load_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      3'b100:  load_d = {24'h000000, shifted_d[7:0]};
      3'b101:  load_d = {16'h0000, shifted_d[15:0]};
      default: load_d = mem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      bad_q       <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mdr_q       <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_REQ;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            funct3_q <= funct3;
            lane_q   <= addr[1:0];
            bad_q    <= ~access_ok_d;
            // A rejected access spends its REQ cycle with the bus idle.
            if (access_ok_d) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (bad_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (mem_ack) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!mem_we_q) mdr_q <= load_d;
          end else if (timeout_hit) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mdr       = mdr_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed load/store/error/timeout/reset transactions against
// a transaction-level model, plus literal expectations per transaction.
module tb_dm_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, start, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, mdr;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  dm_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
    .err(err), .mdr(mdr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Access size in bytes; 0 for encodings with no size.
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit acc_ok(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    if (sz == 0) return 1'b0;
    if (f3[2] && (st || f3 == 3'b110)) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    int m  = ((1 << sz) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] wd);
    case (acc_size(f3))
      1:       return {24'h0, wd[7:0]} * 32'h01010101;
      2:       return {16'h0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (acc_size(f3) == 4) return rd;
    if (acc_size(f3) == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v - 32'h100;
    end else begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v - 32'h10000;
    end
    return v;
  endfunction

  // Transaction-level model: phase 0 idle, 1 waiting on memory, 2 reporting completion.
  int          m_phase, m_cnt;
  logic        m_bad, m_store;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic        e_req, e_we, e_busy, e_done, e_err;
  logic [31:0] e_addr, e_wdata, e_mdr;
  logic [3:0]  e_be;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_cnt <= 0;
      e_req <= 0; e_we <= 0; e_busy <= 0; e_done <= 0; e_err <= 0;
      e_addr <= 0; e_wdata <= 0; e_mdr <= 0; e_be <= 0;
    end else begin
      e_done <= 0;
      e_err  <= 0;
      case (m_phase)
        0: if (start) begin
          m_phase <= 1; e_busy <= 1; m_cnt <= 0;
          m_store <= is_store; m_f3 <= funct3; m_addr <= addr;
          m_bad   <= !acc_ok(is_store, funct3, addr);
          if (acc_ok(is_store, funct3, addr)) begin
            e_req   <= 1;
            e_we    <= is_store;
            e_addr  <= addr & ~32'h3;
            e_be    <= is_store ? lane_mask(funct3, addr) : 4'hF;
            e_wdata <= replicate(funct3, wdata);
          end
        end
        1: if (m_bad) begin
          m_phase <= 2; e_done <= 1; e_err <= 1;
        end else if (mem_ack) begin
          m_phase <= 2; e_done <= 1; e_err <= 0; e_req <= 0;
          if (!m_store) e_mdr <= load_val(m_f3, m_addr, mem_rdata);
        end else if (m_cnt == TO - 1) begin
          m_phase <= 2; e_done <= 1; e_err <= 1; e_req <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
        default: begin
          m_phase <= 0; e_busy <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mem_req", mem_req, e_req);
      chk("mdr", mdr, e_mdr);
      if (e_done) chk("err", err, e_err);
      if (e_req) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", mem_be, e_be);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  int          done_k, req_n, done_n;
  logic        err_d, we_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s, addr_s;

  // One transaction over a fixed 8-cycle window; ack_at=0 means memory never answers.
  task automatic txn(input string nm, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int ack_at, input bit pulse);
    @(negedge clk);
    start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd;
    done_k = 0; req_n = 0; done_n = 0; err_d = 0; we_s = 0; be_s = 0; wd_s = 0; addr_s = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = pulse && (k == 1);
      if (mem_req) begin
        req_n++;
        be_s = mem_be; wd_s = mem_wdata; addr_s = mem_addr; we_s = mem_we;
      end
      mem_ack = mem_req && (k == ack_at);
      if (done) begin
        done_n++;
        if (done_k == 0) begin done_k = k; err_d = err; end
      end
    end
    mem_ack = 0; start = 0;
    $display("txn %-10s done@T+%0d req_cycles=%0d err=%0b mdr=%h", nm, done_k, req_n, err_d, mdr);
    chk({nm, ".done_pulses"}, done_n, 1);
  endtask

  initial begin
    rst = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset.mem_req", mem_req, 0);
    chk("reset.mdr", mdr, 0);
    chk("reset.busy", busy, 0);
    rst = 0;

    txn("LW", 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 0);
    chk("LW.done_k", done_k, 2);
    chk("LW.err", err_d, 0);
    chk("LW.mdr", mdr, 32'hDEADBEEF);
    chk("LW.mem_addr", addr_s, 32'h100);
    chk("LW.mem_be", be_s, 4'b1111);

    txn("LB", 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1, 0);
    chk("LB.mdr", mdr, 32'hFFFFFF80);
    txn("LBU", 0, 3'b100, 32'h103, 0, 32'h80FF1234, 1, 0);
    chk("LBU.mdr", mdr, 32'h00000080);
    txn("LH", 0, 3'b001, 32'h102, 0, 32'h80FF1234, 1, 0);
    chk("LH.mdr", mdr, 32'hFFFF80FF);
    txn("LHU", 0, 3'b101, 32'h102, 0, 32'h80FF1234, 1, 0);
    chk("LHU.mdr", mdr, 32'h000080FF);

    txn("SB", 1, 3'b000, 32'h202, 32'h000000A5, 32'h55555555, 1, 0);
    chk("SB.mem_we", we_s, 1);
    chk("SB.mem_be", be_s, 4'b0100);
    chk("SB.mem_wdata", wd_s, 32'hA5A5A5A5);
    chk("SB.mdr", mdr, 32'h000080FF);
    txn("SH", 1, 3'b001, 32'h202, 32'h00001234, 32'h55555555, 1, 0);
    chk("SH.mem_be", be_s, 4'b1100);
    chk("SH.mem_wdata", wd_s, 32'h12341234);
    chk("SH.mdr", mdr, 32'h000080FF);

    txn("LW_mis", 0, 3'b010, 32'h101, 0, 0, 1, 0);
    chk("LW_mis.req_cycles", req_n, 0);
    chk("LW_mis.done_k", done_k, 2);
    chk("LW_mis.err", err_d, 1);
    txn("SH_mis", 1, 3'b001, 32'h201, 32'h1234, 0, 1, 0);
    chk("SH_mis.req_cycles", req_n, 0);
    chk("SH_mis.err", err_d, 1);
    txn("LD_011", 0, 3'b011, 32'h100, 0, 0, 1, 0);
    chk("LD_011.req_cycles", req_n, 0);
    chk("LD_011.err", err_d, 1);
    txn("ST_100", 1, 3'b100, 32'h100, 0, 0, 1, 0);
    chk("ST_100.err", err_d, 1);

    txn("timeout", 0, 3'b010, 32'h104, 0, 32'hCAFEF00D, 0, 0);
    chk("timeout.req_cycles", req_n, 4);
    chk("timeout.done_k", done_k, 5);
    chk("timeout.err", err_d, 1);
    chk("timeout.mdr", mdr, 32'h000080FF);
    txn("ack_last", 0, 3'b010, 32'h108, 0, 32'h0BADF00D, 4, 0);
    chk("ack_last.err", err_d, 0);
    chk("ack_last.done_k", done_k, 5);
    chk("ack_last.mdr", mdr, 32'h0BADF00D);

    txn("pulse", 0, 3'b010, 32'h10C, 0, 32'h11223344, 3, 1);
    chk("pulse.done_k", done_k, 4);
    chk("pulse.mdr", mdr, 32'h11223344);

    // Reset lands in the second REQ cycle: bus released, mdr cleared, no completion.
    @(negedge clk);
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h300; mem_rdata = 32'h77777777;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("rst_mid.req_before", mem_req, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid.mem_req", mem_req, 0);
    chk("rst_mid.mdr", mdr, 0);
    rst = 0;
    done_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("rst_mid.no_done", done_n, 0);
    $display("txn %-10s reset in REQ, done pulses=%0d mdr=%h", "rst_mid", done_n, mdr);

    // Acks while idle must not disturb anything.
    mem_ack = 1; mem_rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    mem_ack = 0;
    @(negedge clk);
    chk("idle_ack.mdr", mdr, 0);
    chk("idle_ack.done", done, 0);
    $display("txn %-10s ack in IDLE, mdr=%h", "idle_ack", mdr);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
